// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: FSM state encoding, on-board slave address map
// and R/W flag values.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_ADDR      = 4'd2,
    ST_ADDR_ACK  = 4'd3,
    ST_WRITE     = 4'd4,
    ST_WRITE_ACK = 4'd5,
    ST_READ      = 4'd6,
    ST_READ_ACK  = 4'd7,
    ST_STOP      = 4'd8
  } state_e;

  localparam logic [6:0] ADDR_LED = 7'h55;
  localparam logic [6:0] ADDR_FND = 7'h56;
  localparam logic [6:0] ADDR_SW  = 7'h57;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-bit tick generator: one-cycle tick every Q clocks while en is high,
// counter held at zero otherwise so each transaction starts on a clean boundary.
module i2c_clk_div #(
  parameter int Q = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CW'(Q - 1));

  always_comb begin
    cnt_d = '0;
    if (en && !tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_master_core.sv
// Single-byte I2C master (write or read of one byte, open-drain SCL/SDA).
// Define I2C_MASTER_DEBUG_EN to add the debug_state output (FSM encoding).
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int I2C_FREQ_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output wire        scl,
  inout  wire        sda
`ifdef I2C_MASTER_DEBUG_EN
  ,
  output logic [3:0] debug_state
`endif
);
  localparam int Q = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rw_q, rw_d;
  logic       ack_err_q, ack_err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       tick;
  logic       sda_in;

  i2c_clk_div #(.Q(Q)) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy_q),
    .tick (tick)
  );

  assign sda_in = sda;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d   = ST_START;
        phase_d   = 2'd0;
        shreg_d   = {addr, rw};
        rw_d      = rw;
        wdata_d   = wdata;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
      end
    end else if (tick) begin
      phase_d = phase_q + 2'd1;
      if (phase_q == 2'd2) begin
        // End of the SCL-high window: the bus value is stable here.
        case (state_q)
          ST_ADDR_ACK, ST_WRITE_ACK: if (sda_in) ack_err_d = 1'b1;
          ST_READ:                   rx_d = {rx_q[6:0], sda_in};
          default: ;
        endcase
      end else if (phase_q == 2'd3) begin
        case (state_q)
          ST_START: begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd7;
          end
          ST_ADDR, ST_WRITE: begin
            if (bit_cnt_q == 3'd0) begin
              state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
            end
          end
          ST_ADDR_ACK: begin
            bit_cnt_d = 3'd7;
            if (ack_err_q) begin
              state_d = ST_STOP;
            end else if (rw_q == RW_READ) begin
              state_d = ST_READ;
            end else begin
              state_d = ST_WRITE;
              shreg_d = wdata_q;
            end
          end
          ST_WRITE_ACK: state_d = ST_STOP;
          ST_READ: begin
            if (bit_cnt_q == 3'd0) state_d = ST_READ_ACK;
            else                   bit_cnt_d = bit_cnt_q - 3'd1;
          end
          ST_READ_ACK: begin
            state_d = ST_STOP;
            rdata_d = rx_q;
          end
          ST_STOP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Pin drive derived from the next state/phase so the bus pins are registered.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      ST_START: sda_oe_d = phase_d[1];
      ST_ADDR, ST_WRITE: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = ~shreg_d[7];
      end
      ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_READ_ACK:
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
      ST_STOP: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= 2'd0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      rx_q      <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign scl     = scl_oe_q ? 1'b0 : 1'bz;
  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

`ifdef I2C_MASTER_DEBUG_EN
  assign debug_state = state_q;
`endif

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core: bus-level slave model plus bus monitor
// (bytes, ACK slots, SCL period, START/STOP count), one line per transaction.
module tb_i2c_master_core;
  import i2c_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr  = 7'h00;
  logic       rw    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  wire        scl;
  wire        sda;
`ifdef I2C_MASTER_DEBUG_EN
  logic [3:0] debug_state;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       slv_drive = 1'b0;
  logic [7:0] rd_byte;
  logic       mon_clr = 1'b0;

  pullup (scl);
  pullup (sda);
  assign sda = slv_drive ? 1'b0 : 1'bz;

  i2c_master_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .addr   (addr),
    .rw     (rw),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err),
    .scl    (scl),
    .sda    (sda)
`ifdef I2C_MASTER_DEBUG_EN
    ,
    .debug_state(debug_state)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic slave_hit(input logic [6:0] a);
    return (a == ADDR_LED) || (a == ADDR_FND) || (a == ADDR_SW);
  endfunction

  // Bus monitor and slave model, sampled on the falling system clock edge.
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  int         bcnt = 0;
  int         byte_no = 0;
  logic [7:0] sh = 8'h00;
  logic       adr_hit = 1'b0;
  logic       rd_mode = 1'b0;
  logic [7:0] bytes [2];
  logic       acks  [2];
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         rise_cnt = 0;
  int         done_cnt = 0;
  int         last_rise = -1;
  int         per_min = 0;
  int         per_max = 0;

  always @(negedge clk) begin
    scl_p <= scl;
    sda_p <= sda;
    if (mon_clr) begin
      start_cnt <= 0;
      stop_cnt  <= 0;
      rise_cnt  <= 0;
      done_cnt  <= 0;
      last_rise <= -1;
      per_min   <= 1000000;
      per_max   <= 0;
      bytes[0]  <= 8'h00;
      bytes[1]  <= 8'h00;
      acks[0]   <= 1'b0;
      acks[1]   <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (scl_p && scl && (sda != sda_p)) begin
        if (!sda) begin
          start_cnt <= start_cnt + 1;
          bcnt      <= 0;
          byte_no   <= 0;
        end else begin
          stop_cnt <= stop_cnt + 1;
        end
        slv_drive <= 1'b0;
      end else if (!scl_p && scl) begin
        rise_cnt  <= rise_cnt + 1;
        last_rise <= cyc;
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min <= cyc - last_rise;
          if (cyc - last_rise > per_max) per_max <= cyc - last_rise;
        end
        if (bcnt < 8) sh <= {sh[6:0], sda};
        else if (byte_no < 2) acks[byte_no] <= sda;
        bcnt <= bcnt + 1;
      end else if (scl_p && !scl) begin
        if (bcnt == 8) begin
          if (byte_no < 2) bytes[byte_no] <= sh;
          if (byte_no == 0) begin
            adr_hit   <= slave_hit(sh[7:1]);
            rd_mode   <= sh[0];
            slv_drive <= slave_hit(sh[7:1]);
          end else begin
            slv_drive <= adr_hit && !rd_mode;
          end
        end else if (bcnt == 9) begin
          bcnt      <= 0;
          byte_no   <= byte_no + 1;
          slv_drive <= adr_hit && rd_mode && (byte_no == 0) && !rd_byte[7];
        end else if (bcnt >= 1 && bcnt <= 7 && byte_no == 1 && rd_mode && adr_hit) begin
          slv_drive <= !rd_byte[7 - bcnt];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [6:0] a, input logic r, input logic [7:0] wd);
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    @(negedge clk);
    addr  = a;
    rw    = r;
    wdata = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts clocks after the start-sampling edge until done; optional
  // conflicting start re-pulse sampled at clock 500.
  task automatic wait_done(input bit repulse, output int n);
    n = 0;
    while (n < 25000) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (repulse && n == 499) begin
        start = 1'b1;
        addr  = 7'h30;
        rw    = RW_READ;
        wdata = 8'h00;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  int n;

  initial begin
    rd_byte = 8'h3C;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Write 0x55 <- 0xA5, with an ignored start re-pulse at clock 500
    pulse_start(ADDR_LED, RW_WRITE, 8'hA5);
    wait_done(1'b1, n);
    chk("wr_cycles", n, 20000);
    chk("wr_busy_at_done", busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    $display("txn write addr=55 wdata=a5 cycles=%0d ack_err=%0d", n, ack_err);
    chk("wr_addr_byte", bytes[0], 8'hAA);
    chk("wr_data_byte", bytes[1], 8'hA5);
    chk("wr_ack0", acks[0], 1'b0);
    chk("wr_ack1", acks[1], 1'b0);
    chk("wr_ack_err", ack_err, 1'b0);
    chk("wr_done_pulses", done_cnt, 1);
    chk("wr_start_cnt", start_cnt, 1);
    chk("wr_stop_cnt", stop_cnt, 1);
    chk("wr_scl_rises", rise_cnt, 19);
    chk("wr_scl_per_min", per_min, 1000);
    chk("wr_scl_per_max", per_max, 1000);
    chk("wr_busy_idle", busy, 1'b0);

    // Write to absent slave 0x30: address NACK, straight to STOP
    pulse_start(7'h30, RW_WRITE, 8'h11);
    wait_done(1'b0, n);
    chk("nk_cycles", n, 11000);
    repeat (5) @(posedge clk);
    #1;
    $display("txn write addr=30 wdata=11 cycles=%0d ack_err=%0d", n, ack_err);
    chk("nk_addr_byte", bytes[0], 8'h60);
    chk("nk_ack0", acks[0], 1'b1);
    chk("nk_ack_err", ack_err, 1'b1);
    chk("nk_scl_rises", rise_cnt, 10);
    chk("nk_stop_cnt", stop_cnt, 1);
    chk("nk_done_pulses", done_cnt, 1);

    // Reset asserted during the WRITE data phase
    pulse_start(ADDR_FND, RW_WRITE, 8'h0F);
    repeat (12100) @(posedge clk);
    #1;
    chk("rs_ack_err_cleared", ack_err, 1'b0);
    chk("rs_pre_scl", scl, 1'b0);
    chk("rs_pre_sda", sda, 1'b0);
    chk("rs_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rs_scl", scl, 1'b1);
    chk("rs_sda", sda, 1'b1);
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    $display("txn write addr=56 wdata=0f aborted by reset, stops=%0d busy=%0d", stop_cnt, busy);
    chk("rs_no_stop", stop_cnt, 0);
    chk("rs_busy_after", busy, 1'b0);
    chk("rs_done_pulses", done_cnt, 0);

    // Read from 0x57 after the aborted transaction, slave returns 0x3C
    pulse_start(ADDR_SW, RW_READ, 8'h00);
    wait_done(1'b0, n);
    chk("rd_cycles", n, 20000);
    repeat (5) @(posedge clk);
    #1;
    $display("txn read addr=57 cycles=%0d rdata=%02h ack_err=%0d", n, rdata, ack_err);
    chk("rd_addr_byte", bytes[0], 8'hAF);
    chk("rd_bus_byte", bytes[1], 8'h3C);
    chk("rd_rdata", rdata, 8'h3C);
    chk("rd_ack0", acks[0], 1'b0);
    chk("rd_nack_slot", acks[1], 1'b1);
    chk("rd_ack_err", ack_err, 1'b0);
    chk("rd_start_cnt", start_cnt, 1);
    chk("rd_stop_cnt", stop_cnt, 1);
    chk("rd_scl_per_max", per_max, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
